uart_tx: RTL and testbench

UART transmitter paired with the existing RX block. It shares the 16x-oversampling tick from BaudRateGenerator (port baud_rate) and serialises one byte per frame: a start bit, DBIT data bits sent MSB first (the bit order RX expects), an optional parity bit, and a stop bit. It sits between the transmit data source and the tx pad, and can be looped back to RX for self-test.

---
 rtl/uart_pkg.sv | 19 +
 rtl/uart_tx.sv | 128 ++++++++++++
 tb/tb_uart_tx.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, oversampling ratio and parity modes.
// The RX block imports the same package.
package uart_pkg;

    localparam int OVERSAMPLE  = 16;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_e;

endpackage

// File: rtl/uart_tx.sv
// UART transmitter: start bit, DBIT data bits MSB first, optional parity, stop bit.
// Bit timing comes from the shared 16x oversample tick.
import uart_pkg::*;

module uart_tx #(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16,
    parameter int PARITY  = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            baud_rate,
    input  logic [DBIT-1:0] d_in,
    input  logic            tx_start,
    output logic            tx,
    output logic            tx_busy,
    output logic            tx_done
);

    tx_state_e       r_state, w_state_nxt;
    logic [3:0]      r_tick,  w_tick_nxt;
    logic [4:0]      r_stick, w_stick_nxt;
    logic [2:0]      r_bit,   w_bit_nxt;
    logic [DBIT-1:0] r_shift, w_shift_nxt;
    logic            r_par,   w_par_nxt;
    logic            r_tx,    w_tx_nxt;
    logic            r_busy;
    logic            r_done,  w_done_nxt;
    logic            w_bit_end;

    assign w_bit_end = baud_rate && (r_tick == 4'(OVERSAMPLE - 1));

    always_comb begin
        w_state_nxt = r_state;
        w_tick_nxt  = r_tick;
        w_stick_nxt = r_stick;
        w_bit_nxt   = r_bit;
        w_shift_nxt = r_shift;
        w_par_nxt   = r_par;
        w_done_nxt  = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (tx_start) begin
                    w_shift_nxt = d_in;
                    w_tick_nxt  = 4'd0;
                    w_par_nxt   = (PARITY == PARITY_ODD) ? ~^d_in : ^d_in;
                    w_state_nxt = ST_START;
                end
            end
            ST_START: begin
                if (baud_rate) w_tick_nxt = r_tick + 4'd1;
                if (w_bit_end) begin
                    w_bit_nxt   = 3'd0;
                    w_state_nxt = ST_DATA;
                end
            end
            ST_DATA: begin
                if (baud_rate) w_tick_nxt = r_tick + 4'd1;
                if (w_bit_end) begin
                    w_shift_nxt = {r_shift[DBIT-2:0], 1'b0};
                    w_bit_nxt   = r_bit + 3'd1;
                    if (r_bit == 3'(DBIT - 1)) begin
                        w_stick_nxt = 5'd0;
                        w_state_nxt = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
                    end
                end
            end
            ST_PARITY: begin
                if (baud_rate) w_tick_nxt = r_tick + 4'd1;
                if (w_bit_end) begin
                    w_stick_nxt = 5'd0;
                    w_state_nxt = ST_STOP;
                end
            end
            ST_STOP: begin
                // Separate 5-bit counter so the stop bit can span two bit times.
                if (baud_rate) begin
                    if (r_stick == 5'(SB_TICK - 1)) begin
                        w_stick_nxt = 5'd0;
                        w_done_nxt  = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_stick_nxt = r_stick + 5'd1;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase

        // Line level is registered from the next state so the pad never glitches.
        case (w_state_nxt)
            ST_START:  w_tx_nxt = 1'b0;
            ST_DATA:   w_tx_nxt = w_shift_nxt[DBIT-1];
            ST_PARITY: w_tx_nxt = w_par_nxt;
            default:   w_tx_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_tick  <= 4'd0;
            r_stick <= 5'd0;
            r_bit   <= 3'd0;
            r_shift <= '0;
            r_par   <= 1'b0;
            r_tx    <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_tick  <= w_tick_nxt;
            r_stick <= w_stick_nxt;
            r_bit   <= w_bit_nxt;
            r_shift <= w_shift_nxt;
            r_par   <= w_par_nxt;
            r_tx    <= w_tx_nxt;
            r_busy  <= (w_state_nxt != ST_IDLE);
            r_done  <= w_done_nxt;
        end
    end

    assign tx      = r_tx;
    assign tx_busy = r_busy;
    assign tx_done = r_done;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: four instances (plain, even parity, odd parity, two stop bits)
// checked every cycle against a frame-level model, plus literal frame captures.
module tb_uart_tx;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       baud = 1'b0;
    logic [3:0] st;
    logic [7:0] din [4];
    logic [3:0] tx_w, busy_w, done_w;

    int nchk = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    int bcnt = 0;
    always @(negedge clk) begin
        bcnt = (bcnt + 1) % 3;
        baud = (bcnt == 0);
    end

    uart_tx #(.DBIT(8), .SB_TICK(16), .PARITY(0)) u_a (
        .clk(clk), .rst_n(rst_n), .baud_rate(baud), .d_in(din[0]), .tx_start(st[0]),
        .tx(tx_w[0]), .tx_busy(busy_w[0]), .tx_done(done_w[0]));
    uart_tx #(.DBIT(8), .SB_TICK(16), .PARITY(1)) u_even (
        .clk(clk), .rst_n(rst_n), .baud_rate(baud), .d_in(din[1]), .tx_start(st[1]),
        .tx(tx_w[1]), .tx_busy(busy_w[1]), .tx_done(done_w[1]));
    uart_tx #(.DBIT(8), .SB_TICK(16), .PARITY(2)) u_odd (
        .clk(clk), .rst_n(rst_n), .baud_rate(baud), .d_in(din[2]), .tx_start(st[2]),
        .tx(tx_w[2]), .tx_busy(busy_w[2]), .tx_done(done_w[2]));
    uart_tx #(.DBIT(8), .SB_TICK(32), .PARITY(0)) u_sb2 (
        .clk(clk), .rst_n(rst_n), .baud_rate(baud), .d_in(din[3]), .tx_start(st[3]),
        .tx(tx_w[3]), .tx_busy(busy_w[3]), .tx_done(done_w[3]));

    function automatic int par_of(input int k);
        return (k == 1) ? 1 : (k == 2) ? 2 : 0;
    endfunction
    function automatic int sb_of(input int k);
        return (k == 3) ? 32 : 16;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Frame model: a frame is a list of bit levels, each 16 ticks, stop bit SB ticks.
    bit         m_act   [4];
    bit         m_done  [4];
    int         m_ticks [4];
    logic [7:0] m_frame [4];

    function automatic logic exp_tx(input int k);
        int idx;
        if (!m_act[k]) return 1'b1;
        idx = m_ticks[k] / 16;
        if (idx == 0) return 1'b0;
        if (idx <= 8) return m_frame[k][8-idx];
        if (idx == 9 && par_of(k) != 0)
            return (par_of(k) == 2) ? ~^m_frame[k] : ^m_frame[k];
        return 1'b1;
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (!rst_n) begin
                m_act[k]  = 0;
                m_done[k] = 0;
            end else begin
                m_done[k] = 0;
                if (m_act[k]) begin
                    if (baud) m_ticks[k]++;
                    if (m_ticks[k] == (9 + (par_of(k) != 0)) * 16 + sb_of(k)) begin
                        m_act[k]  = 0;
                        m_done[k] = 1;
                    end
                end else if (st[k]) begin
                    m_act[k]   = 1;
                    m_ticks[k] = 0;
                    m_frame[k] = din[k];
                end
            end
        end
    end

    always @(posedge clk) begin
        #1;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("tx[%0d]", k),   tx_w[k],   exp_tx(k));
            chk($sformatf("busy[%0d]", k), busy_w[k], m_act[k]);
            chk($sformatf("done[%0d]", k), done_w[k], m_done[k]);
        end
    end

    // Frame capture: sample the line mid-bit, count ticks while busy.
    logic [31:0] rb [4];
    int          rc [4];
    logic [31:0] lastb [4];
    int          lastt [4];
    int          ndone [4];

    initial for (int k = 0; k < 4; k++) begin
        rb[k] = 0; rc[k] = 0; lastb[k] = 0; lastt[k] = 0; ndone[k] = 0;
    end

    always @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (!rst_n) begin
                rb[k] = 0; rc[k] = 0;
            end else if (done_w[k]) begin
                lastb[k] = rb[k]; lastt[k] = rc[k]; ndone[k]++;
                rb[k] = 0; rc[k] = 0;
            end else if (busy_w[k] && baud) begin
                if (rc[k] % 16 == 7) rb[k] = {rb[k][30:0], tx_w[k]};
                rc[k]++;
            end
        end
    end

    task automatic wait_done(input int k);
        int n;
        n = 0;
        @(posedge clk); #1;
        while (!done_w[k] && n < 3000) begin
            @(posedge clk); #1;
            n++;
        end
        chk($sformatf("done_timeout[%0d]", k), done_w[k], 1);
    endtask

    task automatic pulse(input int k, input logic [7:0] d);
        @(negedge clk);
        din[k] = d; st[k] = 1'b1;
        @(negedge clk);
        st[k] = 1'b0;
    endtask

    initial begin
        int n;
        rst_n = 1'b0;
        st    = 4'b0;
        for (int k = 0; k < 4; k++) din[k] = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tx",   tx_w,   4'hF);
        chk("rst_busy", busy_w, 4'h0);
        chk("rst_done", done_w, 4'h0);
        @(negedge clk) rst_n = 1'b1;

        // Single frame with start latency check
        @(negedge clk);
        din[0] = 8'h99; st[0] = 1'b1;
        @(posedge clk); #1;
        chk("lat_tx",   tx_w[0],   1'b0);
        chk("lat_busy", busy_w[0], 1'b1);
        @(negedge clk) st[0] = 1'b0;
        wait_done(0);
        @(posedge clk); #1;
        chk("single_bits",  lastb[0], 32'h133);
        chk("single_ticks", lastt[0], 160);
        chk("single_ndone", ndone[0], 1);

        // Back-to-back stream; d_in changes right after acceptance
        @(negedge clk);
        din[0] = 8'h99; st[0] = 1'b1;
        @(negedge clk) din[0] = 8'h66;
        wait_done(0);
        chk("gap_tx",   tx_w[0],   1'b1);
        chk("gap_busy", busy_w[0], 1'b0);
        @(posedge clk); #1;
        chk("b2b_start_tx",   tx_w[0],   1'b0);
        chk("b2b_start_busy", busy_w[0], 1'b1);
        chk("b2b_bits0",      lastb[0],  32'h133);
        wait_done(0);
        @(negedge clk) st[0] = 1'b0;
        @(posedge clk); #1;
        chk("b2b_bits1", lastb[0],  32'h0CD);
        chk("b2b_idle",  busy_w[0], 1'b0);
        chk("b2b_ndone", ndone[0],  3);

        // Request while busy is ignored
        pulse(0, 8'h99);
        repeat (200) @(negedge clk);
        din[0] = 8'hFF; st[0] = 1'b1;
        @(negedge clk);
        st[0] = 1'b0; din[0] = 8'h00;
        wait_done(0);
        @(posedge clk); #1;
        chk("busy_bits", lastb[0], 32'h133);
        repeat (50) @(posedge clk);
        #1;
        chk("busy_idle",  busy_w[0], 1'b0);
        chk("busy_ndone", ndone[0],  4);

        // Reset in the middle of data bit 3
        pulse(0, 8'h99);
        n = 0;
        while (m_ticks[0] < 72 && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        chk("rst_reach", (m_ticks[0] >= 72), 1);
        @(negedge clk) rst_n = 1'b0;
        @(posedge clk); #1;
        chk("midrst_tx",   tx_w[0],   1'b1);
        chk("midrst_busy", busy_w[0], 1'b0);
        @(negedge clk) rst_n = 1'b1;
        pulse(0, 8'hA5);
        wait_done(0);
        @(posedge clk); #1;
        chk("post_rst_bits",  lastb[0], 32'h14B);
        chk("post_rst_ticks", lastt[0], 160);
        chk("post_rst_ndone", ndone[0], 5);

        // Even and odd parity on 8'h07
        @(negedge clk);
        din[1] = 8'h07; din[2] = 8'h07; st[1] = 1'b1; st[2] = 1'b1;
        @(negedge clk);
        st[1] = 1'b0; st[2] = 1'b0;
        wait_done(1);
        @(posedge clk); #1;
        chk("even_bits",  lastb[1], 32'h01F);
        chk("even_ticks", lastt[1], 176);
        chk("odd_bits",   lastb[2], 32'h01D);
        chk("odd_ticks",  lastt[2], 176);

        // Two stop bits
        pulse(3, 8'h99);
        wait_done(3);
        @(posedge clk); #1;
        chk("sb2_bits",  lastb[3], 32'h267);
        chk("sb2_ticks", lastt[3], 176);

        chk("ndone_even", ndone[1], 1);
        chk("ndone_odd",  ndone[2], 1);
        chk("ndone_sb2",  ndone[3], 1);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
